// File: rtl/demux_y_dac_8ch_pkg.sv
// rtl/demux_y_dac_8ch_pkg.sv - shared constants and helpers for the 8-lane DAC de-interleaver
package demux_y_dac_8ch_pkg;

  localparam int NCH       = 8;
  localparam int SLOT_W    = 3;
  localparam int DEF_WIDTH = 32;

  // Channel indices shared with the capture-side mux select generator.
  localparam logic [SLOT_W-1:0] CH_FIRST = 3'd0;
  localparam logic [SLOT_W-1:0] CH_LAST  = 3'd7;

  function automatic logic [NCH-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
    return NCH'(1) << s;
  endfunction

endpackage

// File: rtl/demux_y_dac_8ch_if.sv
// rtl/demux_y_dac_8ch_if.sv - interleaved sample stream feeding the de-interleaver
interface demux_y_dac_8ch_if
  import demux_y_dac_8ch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] y_in;
  logic             y_in_valid;
  logic             y_sync;

  modport master (output y_in, output y_in_valid, output y_sync);
  modport slave  (input  y_in, input  y_in_valid, input  y_sync);

endinterface

// File: rtl/demux_y_dac_8ch_slot_counter_8ch.sv
// rtl/demux_y_dac_8ch_slot_counter_8ch.sv - wrapping 3-bit slot counter with sync-load and sticky sync error
module slot_counter_8ch
  import demux_y_dac_8ch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              sync,
  output logic [SLOT_W-1:0] slot,
  output logic [SLOT_W-1:0] target,
  output logic              sync_err
);

  // A sync forces the current sample onto channel 0 regardless of where the counter sits.
  always_comb begin
    target = slot;
    if (adv && sync) target = CH_FIRST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= CH_FIRST;
      sync_err <= 1'b0;
    end else if (adv) begin
      slot <= target + SLOT_W'(1);
      if (sync && slot != CH_FIRST) sync_err <= 1'b1;
    end
  end

endmodule

// File: rtl/demux_y_dac_8ch.sv
// rtl/demux_y_dac_8ch.sv - round-robin de-interleave of one sample stream onto 8 held DAC registers
module demux_y_dac_8ch
  import demux_y_dac_8ch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input  logic                clk,
  input  logic                GlobalReset,
  demux_y_dac_8ch_if.slave    y_bus,
  output logic [WIDTH-1:0]    y_dac_0,
  output logic [WIDTH-1:0]    y_dac_1,
  output logic [WIDTH-1:0]    y_dac_2,
  output logic [WIDTH-1:0]    y_dac_3,
  output logic [WIDTH-1:0]    y_dac_4,
  output logic [WIDTH-1:0]    y_dac_5,
  output logic [WIDTH-1:0]    y_dac_6,
  output logic [WIDTH-1:0]    y_dac_7,
  output logic [NCH-1:0]      y_dac_valid,
  output logic [SLOT_W-1:0]   y_slot,
  output logic                frame_done,
  output logic                frame_err
);

  logic [SLOT_W-1:0] target;
  logic [WIDTH-1:0]  dac_q [NCH];

  slot_counter_8ch u_slot (
    .clk      (clk),
    .rst      (GlobalReset),
    .adv      (y_bus.y_in_valid),
    .sync     (y_bus.y_sync),
    .slot     (y_slot),
    .target   (target),
    .sync_err (frame_err)
  );

  // Only the targeted lane loads; the rest hold so the DACs see stable codes.
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      for (int i = 0; i < NCH; i++) dac_q[i] <= '0;
      y_dac_valid <= '0;
      frame_done  <= 1'b0;
    end else begin
      y_dac_valid <= '0;
      frame_done  <= 1'b0;
      if (y_bus.y_in_valid) begin
        dac_q[target] <= y_bus.y_in;
        y_dac_valid   <= slot_onehot(target);
        frame_done    <= (target == CH_LAST);
      end
    end
  end

  assign y_dac_0 = dac_q[0];
  assign y_dac_1 = dac_q[1];
  assign y_dac_2 = dac_q[2];
  assign y_dac_3 = dac_q[3];
  assign y_dac_4 = dac_q[4];
  assign y_dac_5 = dac_q[5];
  assign y_dac_6 = dac_q[6];
  assign y_dac_7 = dac_q[7];

endmodule

// File: tb/tb_demux_y_dac_8ch.sv
// tb/tb_demux_y_dac_8ch.sv - directed self-checking bench for demux_y_dac_8ch
module tb_demux_y_dac_8ch;

  logic        clk = 1'b0;
  logic        GlobalReset;
  logic [31:0] dac [8];
  logic [7:0]  y_dac_valid;
  logic [2:0]  y_slot;
  logic        frame_done;
  logic        frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;

  demux_y_dac_8ch_if #(.WIDTH(32)) y_bus ();

  demux_y_dac_8ch #(.WIDTH(32)) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .y_bus       (y_bus),
    .y_dac_0     (dac[0]),
    .y_dac_1     (dac[1]),
    .y_dac_2     (dac[2]),
    .y_dac_3     (dac[3]),
    .y_dac_4     (dac[4]),
    .y_dac_5     (dac[5]),
    .y_dac_6     (dac[6]),
    .y_dac_7     (dac[7]),
    .y_dac_valid (y_dac_valid),
    .y_slot      (y_slot),
    .frame_done  (frame_done),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input, then sample just after the edge that registers it.
  task automatic drive(input logic rst, input logic v, input logic s, input logic [31:0] d);
    GlobalReset      = rst;
    y_bus.y_in       = d;
    y_bus.y_in_valid = v;
    y_bus.y_sync     = s;
    @(posedge clk);
    #1;
    if (frame_done) fd_cnt++;
  endtask

  task automatic check_all_clear(input string tag);
    for (int i = 0; i < 8; i++) check_eq($sformatf("%s_dac%0d", tag, i), dac[i], 32'h0);
    check_eq({tag, "_valid"}, {24'h0, y_dac_valid}, 32'h0);
    check_eq({tag, "_slot"},  {29'h0, y_slot},      32'h0);
    check_eq({tag, "_done"},  {31'h0, frame_done},  32'h0);
    check_eq({tag, "_err"},   {31'h0, frame_err},   32'h0);
  endtask

  initial begin
    GlobalReset = 1'b1;
    y_bus.y_in = '0; y_bus.y_in_valid = 1'b0; y_bus.y_sync = 1'b0;
    #2;

    // Reset wins over a valid input
    drive(1, 1, 0, 32'hDEAD_BEEF);
    drive(1, 1, 0, 32'hDEAD_BEEF);
    check_all_clear("reset");

    // Full frame with sync on sample 0
    fd_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      drive(0, 1, (n == 0), 32'h100 + n);
      check_eq($sformatf("frame_dac%0d", n), dac[n], 32'h100 + n);
      check_eq($sformatf("frame_valid%0d", n), {24'h0, y_dac_valid}, 32'h1 << n);
      check_eq($sformatf("frame_done%0d", n), {31'h0, frame_done}, (n == 7) ? 32'h1 : 32'h0);
      check_eq($sformatf("frame_slot%0d", n), {29'h0, y_slot}, (n + 1) % 8);
    end
    check_eq("frame_err", {31'h0, frame_err}, 32'h0);

    // Gaps between samples
    drive(0, 1, 0, 32'hA0);
    drive(0, 1, 0, 32'hA1);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 32'hFFFF_FFFF);
      check_eq($sformatf("gap_slot%0d", k), {29'h0, y_slot}, 32'h2);
      check_eq($sformatf("gap_valid%0d", k), {24'h0, y_dac_valid}, 32'h0);
      check_eq($sformatf("gap_dac2_%0d", k), dac[2], 32'h102);
    end
    check_eq("gap_err_nosync_idle", {31'h0, frame_err}, 32'h0);
    drive(0, 1, 0, 32'hA2);
    check_eq("gap_dac2", dac[2], 32'hA2);
    check_eq("gap_dac0", dac[0], 32'hA0);
    check_eq("gap_dac1", dac[1], 32'hA1);
    check_eq("gap_slot", {29'h0, y_slot}, 32'h3);

    // Wrap: 10 samples from slot 0
    drive(1, 0, 0, 32'h0);
    fd_cnt = 0;
    for (int n = 1; n <= 10; n++) drive(0, 1, (n == 1), n);
    check_eq("wrap_dac0", dac[0], 32'd9);
    check_eq("wrap_dac1", dac[1], 32'd10);
    for (int i = 2; i < 8; i++) check_eq($sformatf("wrap_dac%0d", i), dac[i], i + 1);
    check_eq("wrap_done_cnt", fd_cnt, 32'd1);
    check_eq("wrap_slot", {29'h0, y_slot}, 32'h2);
    check_eq("wrap_err", {31'h0, frame_err}, 32'h0);

    // Mid-frame sync
    drive(1, 0, 0, 32'h0);
    fd_cnt = 0;
    drive(0, 1, 1, 32'h11);
    drive(0, 1, 0, 32'h12);
    drive(0, 1, 0, 32'h13);
    drive(0, 1, 1, 32'h55);
    check_eq("msync_dac0", dac[0], 32'h55);
    check_eq("msync_dac1", dac[1], 32'h12);
    check_eq("msync_dac2", dac[2], 32'h13);
    check_eq("msync_valid", {24'h0, y_dac_valid}, 32'h01);
    check_eq("msync_slot", {29'h0, y_slot}, 32'h1);
    check_eq("msync_err", {31'h0, frame_err}, 32'h1);
    for (int k = 0; k < 4; k++) drive(0, (k != 1), 0, 32'h60 + k);
    check_eq("msync_err_held", {31'h0, frame_err}, 32'h1);
    check_eq("msync_no_done", fd_cnt, 32'd0);
    drive(1, 0, 0, 32'h0);
    check_eq("msync_err_cleared", {31'h0, frame_err}, 32'h0);

    // Reset mid-frame
    for (int n = 0; n < 5; n++) drive(0, 1, (n == 0), 32'h200 + n);
    check_eq("rmid_slot_pre", {29'h0, y_slot}, 32'h5);
    drive(1, 1, 0, 32'h300);
    check_all_clear("rmid");
    drive(0, 1, 0, 32'h77);
    check_eq("rmid_dac0", dac[0], 32'h77);
    check_eq("rmid_valid", {24'h0, y_dac_valid}, 32'h01);
    check_eq("rmid_slot", {29'h0, y_slot}, 32'h1);
    check_eq("rmid_err", {31'h0, frame_err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
